// File: rtl/gbuff_reader_pkg.sv
// Shared types and default widths for the global-buffer read initiator.
package gbuff_reader_pkg;

  // Default data and word-address widths for the global buffer.
  localparam int GB_WORD_SIZE      = 16;
  localparam int GB_WORD_ADDR_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  // Counts the buffer slots that will still be claimed after this cycle:
  // words already queued, plus a word arriving from the SRAM, minus a word leaving.
  // Pop implies a non-empty FIFO, so the subtraction never underflows.
  function automatic logic [1:0] credit_used(input logic [1:0] cnt,
                                             input logic       inflight,
                                             input logic       pop);
    return cnt + {1'b0, inflight} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/gbuff_rd_fifo.sv
// Two-entry skid FIFO that holds SRAM read data ahead of the output stream.
module gbuff_rd_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt_q;

  // Storage, pointers and occupancy; push and pop may occur in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = cnt_q;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/gbuff_reader.sv
// Read-side burst initiator for the global-buffer SRAM with valid/ready output.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_RUN   | issuing one read per cycle while credit is available
// ST_DRAIN | all reads issued; waiting for the last word to be handshaken
// ST_DONE  | one-cycle done pulse, then back to idle
module gbuff_reader
  import gbuff_reader_pkg::*;
#(
  parameter int WORD_SIZE      = GB_WORD_SIZE,
  parameter int WORD_ADDR_BITS = GB_WORD_ADDR_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [WORD_ADDR_BITS-1:0] cmd_base,
  input  logic [WORD_ADDR_BITS:0]   cmd_len,
  output logic                      sram_wen,
  output logic [WORD_ADDR_BITS-1:0] sram_addr,
  input  logic [WORD_SIZE-1:0]      sram_do,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_SIZE-1:0]      out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int A = WORD_ADDR_BITS;
  localparam int W = WORD_SIZE;
  localparam logic [A:0] ONE = (A+1)'(1);

  rd_state_e    state;
  logic [A-1:0] base_q;
  logic [A:0]   len_q;
  logic [A:0]   issued_q;
  logic [A:0]   popped_q;
  logic [A-1:0] addr_q;
  logic         inflight_q;

  logic [1:0]   fifo_count;
  logic [W-1:0] fifo_head;
  logic         pop;
  logic         issue;
  logic [A:0]   remaining;
  logic [A-1:0] issue_addr;
  logic         drain_done;

  gbuff_rd_fifo #(.W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (sram_do),
    .pop   (pop),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Issue is decided in-cycle so a rising out_ready restarts reads immediately.
  always_comb begin
    pop        = out_valid & out_ready;
    remaining  = len_q - issued_q;
    issue_addr = base_q + issued_q[A-1:0];
    issue      = (state == ST_RUN) && (remaining != '0) &&
                 (credit_used(fifo_count, inflight_q, pop) < 2'd2);
    drain_done = !inflight_q &&
                 ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));
  end

  assign sram_wen  = 1'b0;
  assign sram_addr = issue ? issue_addr : addr_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_head;
  assign out_last  = out_valid && (popped_q == (len_q - ONE));

  // Burst sequencing, read bookkeeping and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      inflight_q <= issue;
      done       <= 1'b0;
      if (issue) begin
        addr_q   <= issue_addr;
        issued_q <= issued_q + ONE;
      end
      if (pop) begin
        popped_q <= popped_q + ONE;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            base_q    <= cmd_base;
            len_q     <= cmd_len;
            issued_q  <= '0;
            popped_q  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue && (remaining == ONE)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
